// File: rtl/sm_step_control_pkg.sv
// Shared types and constant helpers for the run/step controller.
package sm_step_control_pkg;

    // Step FSM states; encodings are fixed so they can be decoded on a debug header.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_REPEAT = 3'd3,
        ST_WAIT   = 3'd4
    } step_state_e;

    // Larger of two parameter values.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sm_debouncer.sv
// Synchroniser plus level debouncer: q follows d only after d has held a new
// level for DEBOUNCE_CYCLES consecutive synchronised samples.
module sm_debouncer
    import sm_step_control_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign q        = level_q;

    // Metastability chain; resets to the idle level of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    // Count consecutive disagreeing samples; any agreement restarts the window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_out != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sm_step_control.sv
// Run/step controller feeding sm_top's clkEnable: debounced step button with
// optional auto-repeat, synchronised run switch, and a wrapping step counter.
module sm_step_control
    import sm_step_control_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_n,
    input  logic               run_sw,
    output logic               clk_enable,
    output logic               step_pulse,
    output logic               key_state,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned          TIMER_W     = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam bit                   REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic [TIMER_W-1:0]   DELAY_LAST  = TIMER_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [TIMER_W-1:0]   PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    logic                   key_level;
    logic [SYNC_STAGES-1:0] run_sync_q;
    logic                   run_sync;

    step_state_e            state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   pulse_q, pulse_d;
    logic [COUNT_W-1:0]     count_q, count_d;

    // The button is active-low, so the debouncer tracks the raw level and idles high.
    sm_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_key_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_level)
    );

    assign key_state = ~key_level;

    // Run switch needs only synchronising; a bouncing switch just stutters free-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_q <= '0;
        end else begin
            run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], run_sw};
        end
    end

    assign run_sync = run_sync_q[SYNC_STAGES-1];

    // Step FSM next state, repeat timer and pulse request; release always returns to IDLE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        count_d = pulse_q ? count_q + 1'b1 : count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_state) begin
                    state_d = ST_PRESS;
                    pulse_d = 1'b1;
                end
            end
            ST_PRESS: begin
                timer_d = '0;
                if (!key_state) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (!key_state) begin
                    state_d = ST_IDLE;
                end else if (timer_q == DELAY_LAST) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!key_state) begin
                    state_d = ST_IDLE;
                end else if (timer_q == PERIOD_LAST) begin
                    timer_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!key_state) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, timer, registered pulse and press counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    // Both OR terms come straight from flops.
    assign clk_enable  = run_sync | pulse_q;
    assign step_pulse  = pulse_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_sm_step_control.sv
// Self-checking bench for sm_step_control: a per-cycle behavioural model
// (window debounce, held-run pulse schedule, pulse counting) plus directed
// scenarios with hand-derived pulse cycles.
module tb_sm_step_control;

    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;
    localparam int CW     = 8;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          key_n  = 1'b1;
    logic          run_sw = 1'b0;
    logic          clk_enable;
    logic          step_pulse;
    logic          key_state;
    logic [CW-1:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;
    int plog[$];

    sm_step_control #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD),
        .COUNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .run_sw      (run_sw),
        .clk_enable  (clk_enable),
        .step_pulse  (step_pulse),
        .key_state   (key_state),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit kh[$];   // pressed-level samples, newest first
    bit rq[$];   // run switch samples, newest first
    bit dh[$];   // last DEB levels seen by the debouncer
    bit m_ks;
    int m_run;   // consecutive edges at which key_state was 1
    bit m_pulse;
    int m_count;
    bit m_run_sync;

    task automatic model_reset();
        kh = {};
        rq = {};
        dh = {};
        for (int i = 0; i < SYNC; i++) begin
            kh.push_back(1'b0);
            rq.push_back(1'b0);
        end
        for (int i = 0; i < DEB; i++) dh.push_back(1'b0);
        m_ks       = 1'b0;
        m_run      = 0;
        m_pulse    = 1'b0;
        m_count    = 0;
        m_run_sync = 1'b0;
    endtask

    task automatic model_step();
        bit seen;
        bit all_diff;
        bit new_pulse;
        seen = kh[SYNC-1];
        kh.push_front(!key_n);
        void'(kh.pop_back());
        rq.push_front(run_sw);
        void'(rq.pop_back());
        m_run_sync = rq[SYNC-1];
        // Pulse schedule: first edge of a held run, then DELAY+2 edges in, then every PERIOD.
        m_run     = m_ks ? m_run + 1 : 0;
        new_pulse = (m_run == 1) ||
                    (DELAY > 0 && m_run >= DELAY + 2 && (m_run - DELAY - 2) % PERIOD == 0);
        if (m_pulse) m_count = (m_count + 1) % (1 << CW);
        m_pulse = new_pulse;
        // Level accepted once DEB consecutive samples all disagree with it.
        dh.push_front(seen);
        void'(dh.pop_back());
        all_diff = 1'b1;
        foreach (dh[i]) if (dh[i] == m_ks) all_diff = 1'b0;
        if (all_diff) m_ks = !m_ks;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model, and pulse logging for directed checks.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_step_pulse", int'(step_pulse), 0);
            check("rst_clk_enable", int'(clk_enable), 0);
            check("rst_key_state", int'(key_state), 0);
            check("rst_press_count", int'(press_count), 0);
        end else begin
            check("step_pulse", int'(step_pulse), int'(m_pulse));
            check("clk_enable", int'(clk_enable), int'(m_run_sync | m_pulse));
            check("key_state", int'(key_state), int'(m_ks));
            check("press_count", int'(press_count), m_count);
            if (step_pulse) plog.push_back(cyc - base);
        end
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_test();
        base = cyc;
        plog = {};
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        key_n  = 1'b1;
        run_sw = 1'b0;
        edges(3);
        rst_n = 1'b1;
        edges(3);
    endtask

    int exp3[6] = '{7, 18, 21, 24, 27, 30};

    initial begin
        edges(3);
        rst_n = 1'b1;
        edges(5);

        // T1: single press of 8 cycles
        start_test();
        key_n = 1'b0;
        edges(5);
        check("t1_ks_c5", int'(key_state), 0);
        edges(1);
        check("t1_ks_c6", int'(key_state), 1);
        edges(2);
        check("t1_count_c8", int'(press_count), 1);
        key_n = 1'b1;
        edges(20);
        check("t1_npulses", plog.size(), 1);
        if (plog.size() >= 1) check("t1_pulse_cyc", plog[0], 7);
        check("t1_count", int'(press_count), 1);
        check("t1_ks_released", int'(key_state), 0);

        // T2: bouncing every 2 cycles never qualifies
        do_reset();
        start_test();
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            edges(2);
            key_n = 1'b1;
            edges(2);
        end
        edges(10);
        check("t2_npulses", plog.size(), 0);
        check("t2_count", int'(press_count), 0);
        check("t2_ks", int'(key_state), 0);

        // T3: long hold with auto-repeat
        do_reset();
        start_test();
        key_n = 1'b0;
        edges(31);
        check("t3_count", int'(press_count), 6);
        check("t3_npulses", plog.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < plog.size()) check("t3_pulse_cyc", plog[i], exp3[i]);
        key_n = 1'b1;
        edges(20);

        // T4: run switch plus a press
        do_reset();
        start_test();
        run_sw = 1'b1;
        edges(1);
        check("t4_en_c1", int'(clk_enable), 0);
        edges(1);
        check("t4_en_c2", int'(clk_enable), 1);
        edges(3);
        start_test();
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            check("t4_en_press", int'(clk_enable), 1);
        end
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edges(1);
            check("t4_en_release", int'(clk_enable), 1);
        end
        check("t4_count", int'(press_count), 1);
        check("t4_npulses", plog.size(), 1);
        if (plog.size() >= 1) check("t4_pulse_cyc", plog[0], 7);
        run_sw = 1'b0;
        edges(4);

        // T5: counter wrap after 256 presses
        do_reset();
        for (int p = 0; p < 255; p++) begin
            key_n = 1'b0;
            edges(8);
            key_n = 1'b1;
            edges(8);
        end
        check("t5_count_255", int'(press_count), 255);
        key_n = 1'b0;
        edges(8);
        key_n = 1'b1;
        edges(8);
        check("t5_count_wrap", int'(press_count), 0);

        // T6: reset while the key is held
        do_reset();
        start_test();
        key_n = 1'b0;
        edges(9);
        rst_n = 1'b0;
        edges(3);
        rst_n = 1'b1;
        edges(8);
        check("t6_npulses", plog.size(), 2);
        if (plog.size() >= 2) begin
            check("t6_pulse0", plog[0], 7);
            check("t6_pulse1", plog[1], 19);
        end
        check("t6_count", int'(press_count), 1);
        key_n = 1'b1;
        edges(20);

        // Random: key levels with random hold lengths, run toggles, occasional reset
        do_reset();
        for (int s = 0; s < 400; s++) begin
            key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                edges(2);
                rst_n = 1'b1;
            end
            edges($urandom_range(1, 14));
        end
        key_n  = 1'b1;
        run_sw = 1'b0;
        edges(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
